// File: rtl/uart_rx_multi.sv
// Parametrised oversampling UART receiver: 2-flop synchroniser, mid-bit sampling,
// false-start rejection, stop-bit check, one-word holding register with overrun.
// Optional parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx_multi #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_4x,
  input  logic                 rst_n,
  input  logic                 in_serial,
  input  logic                 in_ack,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_frame_err,
  output logic                 out_parity_err,
  output logic                 out_overrun,
  output logic                 out_busy,
  output logic [2:0]           out_state
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int CW   = $clog2(OVERSAMPLE);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 3 || OVERSAMPLE > 64 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_multi: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   line_s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   ferr_q, ferr_d;
  logic                   commit;
  logic                   word_perr;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q, frame_err_q, overrun_q;

  always_ff @(posedge clk_4x or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], in_serial};
  end
  assign line_s = sync_q[1];

  always_ff @(posedge clk_4x or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  always_ff @(posedge clk_4x or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
  assign word_perr = ((^shift_q) ^ par_q) != 1'(PARITY_ODD);
`else
  assign word_perr = 1'b0;
`endif

  // Every non-idle state counts down; the action of the state happens when cnt reaches 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    commit  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q == S_IDLE) begin
      if (!line_s) begin
        state_d = S_START;
        cnt_d   = CW'(HALF - 1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = CW'(OVERSAMPLE - 1);
      unique case (state_q)
        S_START: begin
          if (line_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            ferr_d  = 1'b0;
          end
        end
        S_DATA: begin
          shift_d = {line_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            stop_d = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          par_d   = line_s;
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
          if (!line_s) ferr_d = 1'b1;
          // Returning to IDLE on the commit edge lets an immediately following start bit resync.
          if (stop_q == LAST_STOP) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake: a word transfers on an edge where out_valid and in_ack are both high;
  // a commit on that same edge wins, otherwise a commit over a held word sets overrun.
  always_ff @(posedge clk_4x or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (commit) begin
      data_q      <= shift_q;
      valid_q     <= 1'b1;
      frame_err_q <= ferr_q | ~line_s;
      overrun_q   <= valid_q & ~in_ack;
    end else if (valid_q && in_ack) begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  always_ff @(posedge clk_4x or negedge rst_n) begin
    if (!rst_n)                 parity_err_q <= 1'b0;
    else if (commit)            parity_err_q <= word_perr;
    else if (valid_q && in_ack) parity_err_q <= 1'b0;
  end
  assign out_parity_err = parity_err_q;
`else
  assign out_parity_err = word_perr;
`endif

  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign out_frame_err = frame_err_q;
  assign out_overrun   = overrun_q;
  assign out_busy      = (state_q != S_IDLE);
  assign out_state     = state_q;

endmodule

// File: tb/tb_uart_rx_multi.sv
// Bench for uart_rx_multi: serial frame driver, auto/manual ack, and a scoreboard
// that checks every word at the moment it is acknowledged.
module tb_uart_rx_multi;
  parameter int DB = 8;
  parameter int OS = 4;
  parameter int SB = 1;
  parameter int PO = 0;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int HALF = OS / 2;
  localparam int NB   = 1 + DB + P + SB;
  localparam int W    = DB + 3;

  logic          clk_4x = 1'b0;
  logic          rst_n, in_serial, in_ack;
  logic [DB-1:0] out_data;
  logic          out_valid, out_frame_err, out_parity_err, out_overrun, out_busy;
  logic [2:0]    out_state;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  e;
  int            checks = 0, errors = 0;
  bit            auto_ack = 1'b0;
  int            ack_delay = 1;
  int            busy_cnt = 0, valid_run = 0, last_valid_cycles = 0;

  uart_rx_multi #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB), .PARITY_ODD(PO)) dut (
    .clk_4x(clk_4x), .rst_n(rst_n), .in_serial(in_serial), .in_ack(in_ack),
    .out_data(out_data), .out_valid(out_valid), .out_frame_err(out_frame_err),
    .out_parity_err(out_parity_err), .out_overrun(out_overrun), .out_busy(out_busy),
    .out_state(out_state)
  );

  always #5 clk_4x = ~clk_4x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Frame: start(0), data LSB first, optional parity, stop bits; each bit lasts OS cycles.
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_bad, input bit par_flip,
                            input bit ack_at_commit);
    logic [NB-1:0] bits;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1+i] = d[i];
    if (P == 1) bits[1+DB] = (^d) ^ (PO != 0) ^ par_flip;
    for (int k = 0; k < SB; k++) bits[1+DB+P+k] = ~stop_bad;
    @(negedge clk_4x);
    if (ack_at_commit) begin
      // 2 synchroniser edges + 1 detect edge, then HALF + OS per remaining bit.
      fork
        begin
          repeat (2 + HALF + OS * (NB - 1)) @(negedge clk_4x);
          in_ack = 1'b1;
          @(negedge clk_4x);
          in_ack = 1'b0;
        end
      join_none
    end
    for (int i = 0; i < NB; i++) begin
      in_serial = bits[i];
      repeat (OS) @(negedge clk_4x);
    end
    in_serial = 1'b1;
    if (stop_bad) repeat (OS) @(negedge clk_4x);
  endtask

  task automatic send_expect(input logic [DB-1:0] d, input bit stop_bad, input bit par_flip);
    bit pbit, perr;
    pbit = (^d) ^ (PO != 0) ^ par_flip;
    perr = (P == 1) ? (((^d) ^ pbit) != (PO != 0)) : 1'b0;
    exp_q.push_back({1'b0, perr, stop_bad, d});
    send_frame(d, stop_bad, par_flip, 1'b0);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 4 * OS * NB + 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk_4x);
      #2;
      budget--;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic manual_ack();
    @(negedge clk_4x);
    in_ack = 1'b1;
    @(negedge clk_4x);
    in_ack = 1'b0;
  endtask

  always begin
    @(negedge clk_4x);
    if (auto_ack && out_valid && !in_ack) begin
      repeat (ack_delay) @(negedge clk_4x);
      in_ack = 1'b1;
      @(negedge clk_4x);
      in_ack = 1'b0;
    end
  end

  // Scoreboard monitor: the held word is consumed on an edge where valid and ack are both high.
  always @(negedge clk_4x) begin
    #1;
    if (out_busy) busy_cnt++;
    if (out_valid) valid_run++;
    if (rst_n && out_valid && in_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h, expected no word", out_data);
      end else begin
        e = exp_q.pop_front();
        check("data", out_data, e[DB-1:0]);
        check("frame_err", out_frame_err, e[DB]);
        check("parity_err", out_parity_err, e[DB+1]);
        check("overrun", out_overrun, e[DB+2]);
      end
      last_valid_cycles = valid_run;
      valid_run = 0;
    end
    if (!out_valid) valid_run = 0;
  end

  initial begin
    repeat (50000) @(posedge clk_4x);
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0; in_serial = 1'b1; in_ack = 1'b0;
    repeat (3) @(negedge clk_4x);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_busy", out_busy, 0);
    check("reset_flags", {out_frame_err, out_parity_err, out_overrun}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_4x);

    auto_ack = 1'b1; ack_delay = 1;
    send_expect(DB'(8'h55), 1'b0, 1'b0);
    wait_drain();
    check("valid_width", last_valid_cycles, 2);
    repeat (2) @(negedge clk_4x);
    #1;
    check("idle_busy", out_busy, 0);
    check("idle_valid", out_valid, 0);

    @(negedge clk_4x);
    busy_cnt = 0;
    in_serial = 1'b0;
    @(negedge clk_4x);
    in_serial = 1'b1;
    repeat (4 * OS) @(negedge clk_4x);
    #2;
    check("glitch_busy_cycles", busy_cnt, HALF);
    check("glitch_no_valid", out_valid, 0);
    send_expect(DB'(8'h3C), 1'b0, 1'b0);
    wait_drain();

    send_expect(DB'(8'hA5), 1'b1, 1'b0);
    wait_drain();
    send_expect(DB'(8'h01), 1'b0, 1'b0);
    wait_drain();

    auto_ack = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 1'b0, DB'(8'h22)});
    send_frame(DB'(8'h11), 1'b0, 1'b0, 1'b0);
    send_frame(DB'(8'h22), 1'b0, 1'b0, 1'b0);
    repeat (OS) @(negedge clk_4x);
    #1;
    check("ovr_valid", out_valid, 1);
    check("ovr_flag", out_overrun, 1);
    check("ovr_data", out_data, DB'(8'h22));
    manual_ack();
    #1;
    check("ovr_ack_valid", out_valid, 0);
    check("ovr_ack_flag", out_overrun, 0);
    wait_drain();

    exp_q.push_back({1'b0, 1'b0, 1'b0, DB'(8'h11)});
    exp_q.push_back({1'b0, 1'b0, 1'b0, DB'(8'h22)});
    send_frame(DB'(8'h11), 1'b0, 1'b0, 1'b0);
    send_frame(DB'(8'h22), 1'b0, 1'b0, 1'b1);
    repeat (OS) @(negedge clk_4x);
    #1;
    check("ackcommit_valid", out_valid, 1);
    check("ackcommit_ovr", out_overrun, 0);
    check("ackcommit_data", out_data, DB'(8'h22));
    manual_ack();
    wait_drain();

    auto_ack = 1'b1;
    if (P == 1) begin
      send_expect(DB'(8'h07), 1'b0, 1'b1);
      wait_drain();
      send_expect(DB'(8'h07), 1'b0, 1'b0);
      wait_drain();
    end

    @(negedge clk_4x);
    in_serial = 1'b0;
    repeat (OS) @(negedge clk_4x);
    in_serial = 1'b1;
    repeat (3 * OS + HALF) @(negedge clk_4x);
    #1;
    check("midframe_busy", out_busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", out_data, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", out_busy, 0);
    check("midrst_flags", {out_frame_err, out_parity_err, out_overrun}, 0);
    repeat (3) @(negedge clk_4x);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_4x);
    send_expect(DB'(8'h81), 1'b0, 1'b0);
    wait_drain();

    for (int n = 0; n < 40; n++) begin
      ack_delay = $urandom_range(0, 3);
      send_expect(DB'($urandom), $urandom_range(0, 7) == 0,
                  (P == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      repeat ($urandom_range(0, 2 * OS)) @(negedge clk_4x);
    end
    wait_drain();
    repeat (4) @(negedge clk_4x);
    #1;
    check("final_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
